cpu_control_fsm: RTL

Parametrised top-level control state machine for the CPU datapath. It sequences HALT → FETCH → (LOAD | STORE) → EXEC and back to FETCH, and adds the following:
- handshake-based memory waits with a configurable bus-timeout trap,
- multi-cycle execute stalls,
- single-step mode,
- encoded trap causes with an acknowledge handshake,
- a retired-instruction counter.

It sits between the instruction decoder/memory interfaces and the datapath enables.

---
 rtl/cpu_control_fsm.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cpu_control_fsm.sv
// Top-level CPU control FSM: HALT/FETCH/LOAD/STORE/EXEC/TRAP sequencing with
// bus-timeout traps, execute stalls, single-step and a retired-instruction counter.
module cpu_control_fsm #(
    parameter int TIMEOUT   = 16,
    parameter int TIMEOUT_W = 8,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             go,
    input  logic             step_mode,
    input  logic             instr_valid,
    input  logic             instr_segv,
    input  logic             invalid_instruction,
    input  logic             instr_is_mem,
    input  logic             ld,
    input  logic             st,
    input  logic             data_ready,
    input  logic             data_segv,
    input  logic             exec_done,
    input  logic             halt,
    input  logic             trap_ack,
    output logic [2:0]       state,
    output logic             fetch_req,
    output logic             mem_req,
    output logic             mem_we,
    output logic             retire,
    output logic             trap,
    output logic [2:0]       trap_cause,
    output logic [CNT_W-1:0] retire_count
);

    typedef enum logic [2:0] {
        S_HALT  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_STORE = 3'd3,
        S_EXEC  = 3'd4,
        S_TRAP  = 3'd5
    } state_t;

    localparam logic [2:0] CAUSE_NONE       = 3'd0;
    localparam logic [2:0] CAUSE_INSTR_SEGV = 3'd1;
    localparam logic [2:0] CAUSE_DATA_SEGV  = 3'd2;
    localparam logic [2:0] CAUSE_ILLEGAL    = 3'd3;
    localparam logic [2:0] CAUSE_FETCH_TO   = 3'd4;
    localparam logic [2:0] CAUSE_DATA_TO    = 3'd5;

    localparam logic [TIMEOUT_W-1:0] WAIT_LIMIT = TIMEOUT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
    localparam logic [TIMEOUT_W-1:0] WAIT_MAX   = '1;

    state_t               state_reg, state_next;
    logic [2:0]           cause_reg, cause_next;
    logic [TIMEOUT_W-1:0] wait_reg, wait_next;
    logic [CNT_W-1:0]     count_reg;
    logic                 stall;
    logic                 timeout_hit;

    // A stall is "nothing happened this cycle" in a state that waits on a handshake.
    assign stall = ((state_reg == S_FETCH) && !instr_segv && !instr_valid) ||
                   (((state_reg == S_LOAD) || (state_reg == S_STORE)) && !data_segv && !data_ready);
    assign timeout_hit = (TIMEOUT != 0) && stall && (wait_reg == WAIT_LIMIT);

    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        case (state_reg)
            S_HALT: begin
                if (go) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (instr_segv) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_INSTR_SEGV;
                end else if (instr_valid) begin
                    if (invalid_instruction) begin
                        state_next = S_TRAP;
                        cause_next = CAUSE_ILLEGAL;
                    end else if (instr_is_mem) begin
                        if (ld) begin
                            state_next = S_LOAD;
                        end else if (st) begin
                            state_next = S_STORE;
                        end else begin
                            state_next = S_TRAP;
                            cause_next = CAUSE_ILLEGAL;
                        end
                    end else begin
                        state_next = S_EXEC;
                    end
                end else if (timeout_hit) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_FETCH_TO;
                end
            end
            S_LOAD, S_STORE: begin
                if (data_segv) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_DATA_SEGV;
                end else if (data_ready) begin
                    state_next = S_EXEC;
                end else if (timeout_hit) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_DATA_TO;
                end
            end
            S_EXEC: begin
                if (exec_done) state_next = (halt || step_mode) ? S_HALT : S_FETCH;
            end
            S_TRAP: begin
                if (trap_ack) begin
                    state_next = S_HALT;
                    cause_next = CAUSE_NONE;
                end
            end
            default: begin
                state_next = S_HALT;
                cause_next = CAUSE_NONE;
            end
        endcase
    end

    always_comb begin
        wait_next = wait_reg;
        if (state_next != state_reg)
            wait_next = '0;
        else if (stall && (wait_reg != WAIT_MAX))
            wait_next = wait_reg + TIMEOUT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= S_HALT;
            cause_reg <= CAUSE_NONE;
            wait_reg  <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            cause_reg <= cause_next;
            wait_reg  <= wait_next;
            if (retire) count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign state        = state_reg;
    assign fetch_req    = (state_reg == S_FETCH);
    assign mem_req      = (state_reg == S_LOAD) || (state_reg == S_STORE);
    assign mem_we       = (state_reg == S_STORE);
    assign trap         = (state_reg == S_TRAP);
    assign retire       = (state_reg == S_EXEC) && exec_done;
    assign trap_cause   = cause_reg;
    assign retire_count = count_reg;

endmodule
